fp_mul_pipe: RTL and testbench
==============================

Name: fp_mul_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 binary multiplier. Successor to the team's single-precision combinational multiplier.
- Adds generic exponent/mantissa widths and a valid/ready stream interface.
- Adds correct special-value handling (zero, inf, NaN), saturating overflow and flush-to-zero underflow.
- Sits in the FP ALU datapath between operand issue and the result writeback arbiter.

Parameters:
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23, stored fraction width. Word width W = 1+EXP_W+MAN_W (default 32).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a  in  W  operand A
- b  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- s  out  W  product
- overflow  out  1  result saturated to ±inf; qualified by out_valid
- underflow  out  1  result flushed to ±0 from a nonzero exact result; qualified by out_valid
- invalid  out  1  0×inf or NaN operand; qualified by out_valid

Behaviour:
- Reset (asynchronous assert, synchronous release): all stage valid bits 0, out_valid=0, s=0, all flags 0. Datapath registers are cleared. Reset mid-operation discards every in-flight op.
- Handshake:
  - Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
  - in_ready = !(out_valid & !out_ready): the whole pipeline stalls together; there are no bubbles to collapse.
  - While stalled, s, out_valid and the flags hold stable.
  - in_ready is independent of in_valid; there is no comb path from in_valid to in_ready.
- Latency: exactly 3 cycles from accept to out_valid with no stall. Throughput 1/cycle.
- S1 (decode):
  - sign = a.sign ^ b.sign.
  - Classify each operand:
    - exp==0: zero. Subnormal inputs are treated as zero (FTZ).
    - exp==all-ones & frac==0: inf.
    - exp==all-ones & frac!=0: NaN.
  - Register significands with the hidden 1, and the special-class bits.
- S2 (multiply):
  - (MAN_W+1)×(MAN_W+1) unsigned product, width 2*MAN_W+2.
  - Exponent sum e = ea + eb - BIAS, held signed in EXP_W+2 bits with no truncation.
- S3 (normalise/round/pack):
  - If product MSB is set, shift right 1 and e += 1.
  - Take MAN_W fraction bits plus guard bit g; sticky st = OR of the remaining low bits.
  - Round per the Optional Feature. If the mantissa rounds to all-ones+1, the fraction becomes 0 and e += 1.
  - Overflow if e >= 2^EXP_W-1: s = {sign, all-ones, 0}, overflow=1.
  - Underflow if e <= 0: s = {sign, 0, 0}, underflow=1.
- Special-value priority, highest first:
  1. Either operand NaN, or zero×inf: canonical qNaN {0, all-ones, 1 followed by 0s}, invalid=1, sign ignored.
  2. Either operand inf: {sign, all-ones, 0}, no flags.
  3. Either operand zero: {sign, 0, 0}, no flags.
  4. Otherwise the normal path.
- Only one of overflow/underflow/invalid may be 1 for any result.

Optional Feature:
- FPMUL_RNE_EN defined: round-to-nearest-even. Increment the fraction when g & (st | lsb).
- FPMUL_RNE_EN undefined: truncate (round toward zero). g and st are ignored, and no rounding-carry logic is built.
- Latency and all other behaviour are identical in both builds.

Test Plan:
- Default params, a=0x3FC00000 (1.5), b=0x40000000 (2.0), out_ready=1 -> s=0x40400000 exactly 3 cycles after accept, flags 0.
- a=0x7F000000, b=0x7F000000 -> s=0x7F800000, overflow=1; a=0xFF000000, b=0x7F000000 -> s=0xFF800000, overflow=1.
- a=0x00800000, b=0x00800000 -> s=0x00000000, underflow=1; a=0x00000000, b=0x7F800000 -> s=0x7FC00000, invalid=1; a=0x7FC00001, b=0x3F800000 -> s=0x7FC00000, invalid=1.
- a=0x3F800001, b=0x3FC00000 -> s=0x3FC00002 with FPMUL_RNE_EN defined, 0x3FC00001 without it.
- Backpressure: issue 5 back-to-back ops with out_ready=0 for cycles 2-8 -> in_ready drops once the output is held; s/out_valid stable while stalled; all 5 results delivered in order, none lost or duplicated.
- Assert rst_n low with 3 ops in flight -> out_valid=0 immediately (asynchronous); after release the first new op emerges 3 cycles after accept and no stale result appears.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined IEEE-754 multiplier (decode / multiply / normalise-pack), valid-ready stream.
// Define FPMUL_RNE_EN for round-to-nearest-even; by default the fraction is truncated.
module fp_mul_pipe #(
  parameter  int unsigned EXP_W = 8,
  parameter  int unsigned MAN_W = 23,
  localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         overflow,
  output logic         underflow,
  output logic         invalid
);

  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam int unsigned EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS_E = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);

  // Single global enable: the whole pipe moves or holds together.
  logic w_adv;
  assign w_adv    = !(out_valid && !out_ready);
  assign in_ready = w_adv;

  // ---------------- S1: decode ----------------
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

  assign w_ea     = a[W-2 -: EXP_W];
  assign w_eb     = b[W-2 -: EXP_W];
  assign w_fa     = a[MAN_W-1:0];
  assign w_fb     = b[MAN_W-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) && (w_fa == '0);
  assign w_b_inf  = (&w_eb) && (w_fb == '0);
  assign w_a_nan  = (&w_ea) && (w_fa != '0);
  assign w_b_nan  = (&w_eb) && (w_fb != '0);

  logic             r1_valid, r1_sign, r1_inv, r1_inf, r1_zero;
  logic [EXP_W-1:0] r1_ea, r1_eb;
  logic [MAN_W:0]   r1_ma, r1_mb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_inv   <= 1'b0;
      r1_inf   <= 1'b0;
      r1_zero  <= 1'b0;
      r1_ea    <= '0;
      r1_eb    <= '0;
      r1_ma    <= '0;
      r1_mb    <= '0;
    end else if (w_adv) begin
      r1_valid <= in_valid;
      r1_sign  <= a[W-1] ^ b[W-1];
      r1_inv   <= w_a_nan || w_b_nan || (w_a_zero && w_b_inf) || (w_a_inf && w_b_zero);
      r1_inf   <= w_a_inf || w_b_inf;
      r1_zero  <= w_a_zero || w_b_zero;
      r1_ea    <= w_ea;
      r1_eb    <= w_eb;
      r1_ma    <= {1'b1, w_fa};
      r1_mb    <= {1'b1, w_fb};
    end
  end

  // ---------------- S2: multiply ----------------
  logic [PW-1:0] w_prod;
  logic [EW-1:0] w_esum;

  assign w_prod = {{(MAN_W + 1){1'b0}}, r1_ma} * {{(MAN_W + 1){1'b0}}, r1_mb};
  // Two's-complement in EW bits; no wrap possible for ea, eb < 2^EXP_W.
  assign w_esum = {2'b00, r1_ea} + {2'b00, r1_eb} - BIAS_E;

  logic          r2_valid, r2_sign, r2_inv, r2_inf, r2_zero;
  logic [PW-1:0] r2_prod;
  logic [EW-1:0] r2_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_inv   <= 1'b0;
      r2_inf   <= 1'b0;
      r2_zero  <= 1'b0;
      r2_prod  <= '0;
      r2_exp   <= '0;
    end else if (w_adv) begin
      r2_valid <= r1_valid;
      r2_sign  <= r1_sign;
      r2_inv   <= r1_inv;
      r2_inf   <= r1_inf;
      r2_zero  <= r1_zero;
      r2_prod  <= w_prod;
      r2_exp   <= w_esum;
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  logic          w_msb;
  logic [PW-1:0] w_norm;
  logic [MAN_W-1:0] w_frac_t, w_frac;
  logic [EW-1:0] w_exp_n, w_exp_f;
  logic          w_unused_bits;

  // After normalising, the hidden one always sits at bit PW-1.
  assign w_msb    = r2_prod[PW-1];
  assign w_norm   = w_msb ? r2_prod : {r2_prod[PW-2:0], 1'b0};
  assign w_frac_t = w_norm[PW-2 -: MAN_W];
  assign w_exp_n  = r2_exp + {{(EW - 1){1'b0}}, w_msb};

`ifdef FPMUL_RNE_EN
  logic           w_g, w_st, w_inc;
  logic [MAN_W:0] w_frac_r;

  assign w_g      = w_norm[MAN_W];
  assign w_st     = |w_norm[MAN_W-1:0];
  assign w_inc    = w_g && (w_st || w_frac_t[0]);
  assign w_frac_r = {1'b0, w_frac_t} + {{MAN_W{1'b0}}, w_inc};
  // A carry out leaves the low bits zero, so only the exponent needs bumping.
  assign w_frac   = w_frac_r[MAN_W-1:0];
  assign w_exp_f  = w_exp_n + {{(EW - 1){1'b0}}, w_frac_r[MAN_W]};
  assign w_unused_bits = w_norm[PW-1];
`else
  assign w_frac   = w_frac_t;
  assign w_exp_f  = w_exp_n;
  assign w_unused_bits = ^{w_norm[PW-1], w_norm[MAN_W:0]};
`endif

  logic [W-1:0] w_res;
  logic         w_ovf, w_unf, w_inv;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inv = 1'b0;
    if (r2_inv) begin
      w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
      w_inv = 1'b1;
    end else if (r2_inf) begin
      w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (r2_zero) begin
      w_res = {r2_sign, {(EXP_W + MAN_W){1'b0}}};
    end else if (!w_exp_f[EW-1] && (w_exp_f >= EMAX_E)) begin
      w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_ovf = 1'b1;
    end else if (w_exp_f[EW-1] || (w_exp_f == '0)) begin
      w_res = {r2_sign, {(EXP_W + MAN_W){1'b0}}};
      w_unf = 1'b1;
    end else begin
      w_res = {r2_sign, w_exp_f[EXP_W-1:0], w_frac};
    end
  end

  logic         r_out_valid, r_ovf, r_unf, r_inv;
  logic [W-1:0] r_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_s         <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_inv       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r2_valid;
      if (r2_valid) begin
        r_s   <= w_res;
        r_ovf <= w_ovf;
        r_unf <= w_unf;
        r_inv <= w_inv;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign invalid   = r_inv;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe (default 8/23 parameters); honours FPMUL_RNE_EN.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        overflow;
  logic        underflow;
  logic        invalid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One op with no backpressure; checks accept, 3-cycle latency, product and flags {ovf,unf,inv}.
  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] es, input logic [2:0] ef);
    in_valid  = 1'b1;
    a         = ia;
    b         = ib;
    out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    tick;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, {31'b0, out_valid}, 32'd0);
    tick;
    chk({tag, "_lat2"}, {31'b0, out_valid}, 32'd0);
    tick;
    chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_s"}, s, es);
    chk({tag, "_flg"}, {29'b0, overflow, underflow, invalid}, {29'b0, ef});
  endtask

  logic [31:0] bp_a [5] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 32'hBF800000, 32'h3F000000};
  logic [31:0] bp_b [5] = '{32'h40000000, 32'h40000000, 32'h40400000, 32'h40A00000, 32'h3F000000};
  logic [31:0] bp_s [5] = '{32'h40400000, 32'h40800000, 32'h41100000, 32'hC0A00000, 32'h3E800000};

  int          idx_in;
  int          n_out;
  logic        saw_stall;
  logic        prev_stall;
  logic [31:0] prev_s;
  logic        acc;
  logic        del;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", {31'b0, out_valid}, 32'd0);
    chk("rst_s", s, 32'd0);
    chk("rst_flg", {29'b0, overflow, underflow, invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    run_op("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);
    run_op("ovf_pos", 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100);
    run_op("ovf_neg", 32'hFF000000, 32'h7F000000, 32'hFF800000, 3'b100);
    run_op("unf", 32'h00800000, 32'h00800000, 32'h00000000, 3'b010);
    run_op("zero_x_inf", 32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b001);
    run_op("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001);
    run_op("inf_x_neg", 32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000);
    run_op("neg_zero", 32'h80000000, 32'h40000000, 32'h80000000, 3'b000);
    run_op("msb_norm", 32'h40400000, 32'h40400000, 32'h41100000, 3'b000);
`ifdef FPMUL_RNE_EN
    run_op("round", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000);
`else
    run_op("round", 32'h3F800001, 32'h3FC00000, 32'h3FC00001, 3'b000);
`endif

    // Backpressure: out_ready low during loop cycles 2..8.
    idx_in     = 0;
    n_out      = 0;
    saw_stall  = 1'b0;
    prev_stall = 1'b0;
    prev_s     = '0;
    tick;
    for (int c = 1; c <= 20; c++) begin
      in_valid  = (idx_in < 5);
      if (idx_in < 5) begin
        a = bp_a[idx_in];
        b = bp_b[idx_in];
      end
      out_ready = !(c >= 2 && c <= 8);
      #1;
      if (prev_stall) begin
        chk("bp_hold_v", {31'b0, out_valid}, 32'd1);
        chk("bp_hold_s", s, prev_s);
      end
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (!in_ready) saw_stall = 1'b1;
      if (del) begin
        if (n_out < 5) chk("bp_s", s, bp_s[n_out]);
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_s     = s;
      tick;
      if (acc) idx_in++;
    end
    in_valid = 1'b0;
    chk("bp_count", n_out, 32'd5);
    chk("bp_stall_seen", {31'b0, saw_stall}, 32'd1);

    // Reset with three ops in flight.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 32'h3FC00000; b = 32'h40000000;
    tick;
    a = 32'h40000000; b = 32'h40000000;
    tick;
    a = 32'h40400000; b = 32'h40400000;
    tick;
    in_valid = 1'b0;
    chk("rst_pre_v", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_v", {31'b0, out_valid}, 32'd0);
    chk("rst_async_s", s, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("rst_no_stale", {31'b0, out_valid}, 32'd0);
    end
    run_op("post_rst", 32'hBF800000, 32'h40A00000, 32'hC0A00000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
